// File: rtl/serial_deser.sv
// serial_deser: start/data/stop frame receiver with a one-entry valid/ready holding buffer.
// Define SERIAL_DESER_PARITY_EN to add an even-parity bit after the data and a parity_err_o output.
module serial_deser #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             bit_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
`ifdef SERIAL_DESER_PARITY_EN
  output logic             parity_err_o,
`endif
  output logic             overrun_o
);
  localparam int CW = $clog2(WIDTH);
`ifdef SERIAL_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif
  state_t state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic last, good, bad, load;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy_o = state != IDLE;
  // A good frame may load the buffer when it is empty or being drained on this edge
  assign load = good && (!valid_o || ready_i);
`ifdef SERIAL_DESER_PARITY_EN
  logic par, par_nx;
`endif
  always_comb begin
    state_nx = state;
    sr_nx = sr;
    cnt_nx = cnt;
    good = 1'b0;
    bad = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
    par_nx = par;
`endif
    if (bit_en)
      case (state)
        IDLE: begin
          state_nx = sdi ? IDLE : DATA;
          cnt_nx = sdi ? cnt : '0;
        end
        DATA: begin
          sr_nx = MSB_FIRST ? {sr[WIDTH-2:0], sdi} : {sdi, sr[WIDTH-1:1]};
          cnt_nx = last ? cnt : cnt + 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
          state_nx = last ? PARITY : DATA;
`else
          state_nx = last ? STOP : DATA;
`endif
        end
`ifdef SERIAL_DESER_PARITY_EN
        PARITY: begin
          par_nx = sdi ^ (^sr);
          state_nx = STOP;
        end
`endif
        STOP: begin
          good = sdi;
          bad = !sdi;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (!nrst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      sr <= sr_nx;
      cnt <= cnt_nx;
    end
  always_ff @(posedge clk)
    if (!nrst) begin
      data_o <= '0;
      valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      frame_err_o <= bad;
      if (load) data_o <= sr;
      valid_o <= load ? 1'b1 : (valid_o && !ready_i);
      if (good && !load) overrun_o <= 1'b1;
    end
`ifdef SERIAL_DESER_PARITY_EN
  always_ff @(posedge clk)
    if (!nrst) begin
      par <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      par <= par_nx;
      parity_err_o <= load ? par : (parity_err_o && !(valid_o && ready_i));
    end
`endif
endmodule
